// File: rtl/conv_pkg.sv
// Shared definitions for the float16 convolution datapath: default geometry,
// flattened bus widths, counter widths and the window element offset helper.
package conv_pkg;

  // Counter width for a 0..n-1 counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DATA_WIDTH    = 16;
  localparam int INPUT_CHANNEL = 1;
  localparam int IMAGE_LENGTH  = 5;
  localparam int IMAGE_WIDTH   = 5;
  localparam int WEIGHT_LENGTH = 3;
  localparam int WEIGHT_WIDTH  = 3;

  localparam int WIN_ELEMS = WEIGHT_LENGTH * WEIGHT_WIDTH;
  localparam int PIX_BITS  = INPUT_CHANNEL * DATA_WIDTH;
  localparam int WIN_BITS  = PIX_BITS * WIN_ELEMS;
  localparam int ROW_BITS  = cnt_width(IMAGE_LENGTH);
  localparam int COL_BITS  = cnt_width(IMAGE_WIDTH);

  // Bit offset of element (channel a, row r, column c) inside a flattened
  // [0:N-1] window bus; r=0 is the oldest row, c=0 the leftmost column.
  function automatic int elem_idx(input int a, input int r, input int c,
                                  input int k_l = WEIGHT_LENGTH,
                                  input int k_w = WEIGHT_WIDTH,
                                  input int dw  = DATA_WIDTH);
    return (a * k_l * k_w + r * k_w + c) * dw;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bus of conv_window_gen.
// Optional window coordinates are present when CONV_WINDOW_POS_EN is defined.
// Both streams use valid/ready: a transfer happens on a clock edge where
// valid and ready are both high; a producer holding valid keeps its data
// stable until that edge, and ready may depend combinationally on valid.
interface conv_window_gen_if
  import conv_pkg::*;
#(
  parameter int data_width    = DATA_WIDTH,
  parameter int input_channel = INPUT_CHANNEL,
  parameter int image_length  = IMAGE_LENGTH,
  parameter int image_width   = IMAGE_WIDTH,
  parameter int weight_length = WEIGHT_LENGTH,
  parameter int weight_width  = WEIGHT_WIDTH
);
  localparam int PIX_W = input_channel * data_width;
  localparam int WIN_W = PIX_W * weight_length * weight_width;

  logic [0:PIX_W-1] pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic [0:WIN_W-1] window;
  logic             window_valid;
  logic             window_ready;
  logic             window_last;
  logic             frame_done;
`ifdef CONV_WINDOW_POS_EN
  localparam int ROW_W = cnt_width(image_length);
  localparam int COL_W = cnt_width(image_width);
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
`endif

  // Window generator side: consumes pixels, produces windows.
  modport master (
    input  pix_in, pix_valid, window_ready,
    output pix_ready, window, window_valid, window_last, frame_done
`ifdef CONV_WINDOW_POS_EN
    , output win_row, win_col
`endif
  );

  // Environment side: pixel source and window consumer.
  modport slave (
    output pix_in, pix_valid, window_ready,
    input  pix_ready, window, window_valid, window_last, frame_done
`ifdef CONV_WINDOW_POS_EN
    , input win_row, win_col
`endif
  );

endinterface

// File: rtl/line_buffer_row.sv
// One circular row buffer: depth entries indexed by column. The entry at
// addr is presented on shift_out (old contents) while a write replaces it,
// so a chain of these shifts a column of pixels up one row per accept.
module line_buffer_row #(
  parameter int data_width = 16,
  parameter int depth      = 5,
  parameter int addr_width = 3
) (
  input  logic                  clk,
  input  logic                  write,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] data,
  output logic [data_width-1:0] shift_out
);
  logic [data_width-1:0] mem [depth];

  // Storage write; contents are intentionally never cleared.
  always_ff @(posedge clk) begin
    if (write) mem[addr] <= data;
  end

  assign shift_out = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming K_L x K_W sliding-window generator (stride 1, no padding) for a
// raster-order pixel stream. Windows are flattened in the conv unit layout.
// Define CONV_WINDOW_POS_EN to add win_row/win_col window coordinates.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int data_width    = DATA_WIDTH,
  parameter int input_channel = INPUT_CHANNEL,
  parameter int image_length  = IMAGE_LENGTH,
  parameter int image_width   = IMAGE_WIDTH,
  parameter int weight_length = WEIGHT_LENGTH,
  parameter int weight_width  = WEIGHT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  conv_window_gen_if.master bus
);
  localparam int DW    = data_width;
  localparam int IC    = input_channel;
  localparam int KL    = weight_length;
  localparam int KW    = weight_width;
  localparam int H     = image_length;
  localparam int W     = image_width;
  localparam int ROW_W = cnt_width(H);
  localparam int COL_W = cnt_width(W);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);
  localparam logic [ROW_W-1:0] ROW_WIN0 = ROW_W'(KL - 1);
  localparam logic [COL_W-1:0] COL_WIN0 = COL_W'(KW - 1);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             accept;
  logic             qualify;
  logic             last_pix;
  logic             valid_q;
  logic             last_q;
  logic             done_q;

  // col_new[a][r]: column entering the window on accept, r=0 oldest row.
  logic [DW-1:0] col_new [IC][KL];
  logic [DW-1:0] win     [IC][KL][KW];

  // A held window blocks input; nothing is accepted while in reset.
  assign bus.pix_ready = !reset && (!valid_q || bus.window_ready);
  assign accept        = bus.pix_valid && bus.pix_ready;
  assign last_pix      = (row == ROW_LAST) && (col == COL_LAST);
  assign qualify       = accept && (row >= ROW_WIN0) && (col >= COL_WIN0);

  for (genvar a = 0; a < IC; a++) begin : g_chan
    assign col_new[a][KL-1] = bus.pix_in[a*DW +: DW];
    // Buffer r feeds row r of the new column and is refilled from row r+1.
    for (genvar r = 0; r < KL - 1; r++) begin : g_row
      line_buffer_row #(
        .data_width (DW),
        .depth      (W),
        .addr_width (COL_W)
      ) u_row (
        .clk       (clk),
        .write     (accept),
        .addr      (col),
        .data      (col_new[a][r+1]),
        .shift_out (col_new[a][r])
      );
    end
    for (genvar r = 0; r < KL; r++) begin : g_wr
      for (genvar c = 0; c < KW; c++) begin : g_wc
        assign bus.window[elem_idx(a, r, c, KL, KW, DW) +: DW] = win[a][r][c];
      end
    end
  end

  // Window shift register: shift left one column and load the new column.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int a = 0; a < IC; a++) begin
        for (int r = 0; r < KL; r++) begin
          for (int c = 0; c < KW - 1; c++) win[a][r][c] <= win[a][r][c+1];
          win[a][r][KW-1] <= col_new[a][r];
        end
      end
    end
  end

  // Raster counters, window valid/last and end-of-frame pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row     <= '0;
      col     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= accept && last_pix;
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (qualify) begin
        valid_q <= 1'b1;
        last_q  <= last_pix;
      end else if (bus.window_ready) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign bus.window_valid = valid_q;
  assign bus.window_last  = last_q;
  assign bus.frame_done   = done_q;

`ifdef CONV_WINDOW_POS_EN
  logic [ROW_W-1:0] win_row_q;
  logic [COL_W-1:0] win_col_q;

  // Top-left coordinate, loaded with the window it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (qualify) begin
      win_row_q <= row - ROW_WIN0;
      win_col_q <= col - COL_WIN0;
    end
  end

  assign bus.win_row = win_row_q;
  assign bus.win_col = win_col_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 5x5 frame, 3x3 window, two channels.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int IC    = 2;
  localparam int DW    = 16;
  localparam int W     = 5;
  localparam int WIN_W = IC * 3 * 3 * DW;

  typedef struct {
    int   trig;   // pixel index whose accept completes the window
    int   tl;     // pixel index of the window's top-left element
    logic last;   // window_last expected with this window
  } win_vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_window_gen_if #(.input_channel(IC)) bus ();
  conv_window_gen #(.input_channel(IC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int win_seen = 0;
  int done_seen = 0;
  logic [WIN_W-1:0] exp_q[$];
  logic             exp_last_q[$];
  win_vec_t         vecs [9];
  logic [WIN_W-1:0] mon_win;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_win(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected window with top-left pixel tl; channel bases b0/b1.
  function automatic logic [WIN_W-1:0] build_win(input int tl, input logic [15:0] b0, input logic [15:0] b1);
    logic [0:WIN_W-1] v;
    v = '0;
    for (int a = 0; a < IC; a++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          v[elem_idx(a, r, c) +: DW] = ((a == 0) ? b0 : b1) + 16'(tl + r * W + c);
    return v;
  endfunction

  function automatic logic in_table(input int idx);
    for (int i = 0; i < 9; i++) if (vecs[i].trig == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_frame(input logic [15:0] b0, input logic [15:0] b1, input int max_trig);
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].trig <= max_trig) begin
        exp_q.push_back(build_win(vecs[i].tl, b0, b1));
        exp_last_q.push_back(vecs[i].last);
      end
    end
  endtask

  // Presents one pixel and returns 1 time unit after the edge that takes it.
  task automatic send_pixel(input int idx, input logic [15:0] b0, input logic [15:0] b1);
    logic ok;
    bus.pix_in[0 +: DW]  = b0 + 16'(idx);
    bus.pix_in[DW +: DW] = b1 + 16'(idx);
    bus.pix_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.pix_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      failures++;
      $display("FAIL pix_accept_timeout: pixel %0d not accepted within 100 cycles", idx);
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.pix_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input logic [15:0] b0, input logic [15:0] b1, input logic gaps);
    for (int idx = 0; idx < 25; idx++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 2));
      send_pixel(idx, b0, b1);
    end
  endtask

  // Scoreboard: every window handed over is checked against the queue.
  always @(negedge clk) begin
    if (!reset && bus.window_valid && bus.window_ready) begin
      win_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_window: got %h expected none", bus.window);
      end else begin
        mon_win = bus.window;
        check_win("window", mon_win, exp_q.pop_front());
        check("window_last", 64'(bus.window_last), 64'(exp_last_q.pop_front()));
      end
    end
    if (!reset && bus.frame_done) done_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]      ch1_exp [9];
    logic [0:WIN_W-1] wcopy;
    logic [WIN_W-1:0] snap;
    logic [WIN_W-1:0] cur;
    int w0;
    int d0;

    vecs[0] = '{12, 0,  1'b0};
    vecs[1] = '{13, 1,  1'b0};
    vecs[2] = '{14, 2,  1'b0};
    vecs[3] = '{17, 5,  1'b0};
    vecs[4] = '{18, 6,  1'b0};
    vecs[5] = '{19, 7,  1'b0};
    vecs[6] = '{22, 10, 1'b0};
    vecs[7] = '{23, 11, 1'b0};
    vecs[8] = '{24, 12, 1'b1};
    ch1_exp = '{16'h0100, 16'h0101, 16'h0102, 16'h0105, 16'h0106,
                16'h0107, 16'h010A, 16'h010B, 16'h010C};

    bus.pix_in       = '0;
    bus.pix_valid    = 1'b0;
    bus.window_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_pix_ready", 64'(bus.pix_ready), 64'd0);
    check("reset_window_valid", 64'(bus.window_valid), 64'd0);
    check("reset_window_last", 64'(bus.window_last), 64'd0);
    check("reset_frame_done", 64'(bus.frame_done), 64'd0);
    reset = 1'b0;
    #1;
    check("post_reset_pix_ready", 64'(bus.pix_ready), 64'd1);
    @(posedge clk);
    #1;

    // Gap-free frame: window latency, channel-1 layout, last and frame_done
    push_frame(16'h0000, 16'h0100, 99);
    w0 = win_seen;
    d0 = done_seen;
    for (int idx = 0; idx < 25; idx++) begin
      send_pixel(idx, 16'h0000, 16'h0100);
      check($sformatf("valid_after_pix%0d", idx), 64'(bus.window_valid), 64'(in_table(idx)));
      if (idx == 12) begin
        wcopy = bus.window;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            check($sformatf("ch1_r%0d_c%0d", r, c), 64'(wcopy[elem_idx(1, r, c) +: DW]), 64'(ch1_exp[r*3+c]));
      end
      if (idx == 24) begin
        check("frame_done_pulse", 64'(bus.frame_done), 64'd1);
        check("last_with_pix24", 64'(bus.window_last), 64'd1);
      end
    end
    @(posedge clk);
    #1;
    check("frame_done_one_cycle", 64'(bus.frame_done), 64'd0);
    idle(1);
    check("frame1_windows", 64'(win_seen - w0), 64'd9);
    check("frame1_done_count", 64'(done_seen - d0), 64'd1);

    // Backpressure: hold the first window for 3 cycles
    push_frame(16'h0000, 16'h0100, 99);
    bus.window_ready = 1'b0;
    for (int idx = 0; idx < 13; idx++) send_pixel(idx, 16'h0000, 16'h0100);
    snap = build_win(0, 16'h0000, 16'h0100);
    bus.pix_in[0 +: DW]  = 16'h000D;
    bus.pix_in[DW +: DW] = 16'h010D;
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_pix_ready", i), 64'(bus.pix_ready), 64'd0);
      check($sformatf("stall%0d_valid", i), 64'(bus.window_valid), 64'd1);
      check($sformatf("stall%0d_last", i), 64'(bus.window_last), 64'd0);
      cur = bus.window;
      check_win($sformatf("stall%0d_window", i), cur, snap);
      @(posedge clk);
      #1;
    end
    bus.window_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    check("release_valid", 64'(bus.window_valid), 64'd1);
    cur = bus.window;
    check_win("release_window", cur, build_win(1, 16'h0000, 16'h0100));
    for (int idx = 14; idx < 25; idx++) send_pixel(idx, 16'h0000, 16'h0100);
    idle(2);

    // Random input gaps: same window sequence and count
    push_frame(16'h0000, 16'h0100, 99);
    w0 = win_seen;
    d0 = done_seen;
    run_frame(16'h0000, 16'h0100, 1'b1);
    idle(2);
    check("gap_windows", 64'(win_seen - w0), 64'd9);
    check("gap_done_count", 64'(done_seen - d0), 64'd1);

    // Reset after pixel 17, then a full restarted frame
    push_frame(16'h0000, 16'h0100, 14);
    for (int idx = 0; idx < 18; idx++) send_pixel(idx, 16'h0000, 16'h0100);
    check("pre_reset_valid", 64'(bus.window_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("reset_drops_valid", 64'(bus.window_valid), 64'd0);
    check("reset_drops_ready", 64'(bus.pix_ready), 64'd0);
    check("reset_queue_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    push_frame(16'h0000, 16'h0100, 99);
    w0 = win_seen;
    d0 = done_seen;
    run_frame(16'h0000, 16'h0100, 1'b0);
    idle(2);
    check("restart_windows", 64'(win_seen - w0), 64'd9);
    check("restart_done_count", 64'(done_seen - d0), 64'd1);

    // Two frames back to back
    push_frame(16'h0000, 16'h0100, 99);
    push_frame(16'h1000, 16'h1100, 99);
    w0 = win_seen;
    d0 = done_seen;
    run_frame(16'h0000, 16'h0100, 1'b0);
    run_frame(16'h1000, 16'h1100, 1'b0);
    idle(2);
    check("b2b_windows", 64'(win_seen - w0), 64'd18);
    check("b2b_done_count", 64'(done_seen - d0), 64'd2);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming sliding-window generator directly upstream of the float16 convolution unit.
- Accepts a raster-order pixel stream of input_channel parallel float16 samples and builds weight_length x weight_width windows with stride 1 and no padding.
- Presents each window as one flattened bus laid out exactly as the conv unit's image input.
- Treats data as raw 16-bit patterns; performs no arithmetic on pixel values.

Parameters:
- data_width, 16, bits per sample (float16 pattern)
- input_channel, 1, channels carried in parallel per pixel
- image_length, 5, rows per frame (H)
- image_width, 5, columns per frame (W)
- weight_length, 3, window rows (K_L); requires image_length >= weight_length
- weight_width, 3, window columns (K_W); requires image_width >= weight_width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- pix_in  in  input_channel*data_width  one pixel; channel a at bits [a*data_width +: data_width], big-endian [0:N-1] indexing
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block can accept pix_in this cycle
- window  out  input_channel*K_L*K_W*data_width  [0:N-1]; element (a,r,c) at (a*K_L*K_W + r*K_W + c)*data_width; r=0 is oldest row, c=0 is leftmost column
- window_valid  out  1  window holds a complete window
- window_ready  in  1  consumer takes window this cycle
- window_last  out  1  with window_valid: last window of the frame
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port named reset.
- Reset values: pix_ready 0 while reset is high, then combinational; window_valid 0, window_last 0, frame_done 0, row/col counters 0. window contents are don't-care while window_valid is 0. Line buffers are not cleared.
- Accept: a pixel is accepted when pix_valid && pix_ready.
- pix_ready: equals !window_valid || window_ready. A held window blocks input, which gives backpressure.
- Storage per channel:
  - K_L-1 row buffers of W entries each; circular, indexed by col.
  - A K_L x K_W shift-register window.
- On accept at (row, col):
  - The window shifts left one column.
  - The new right column is taken from the row buffers at col (oldest first) plus pix_in.
  - The row buffers are updated at col, shifting pix_in up the chain.
- Counters: col increments on accept. At W-1, col wraps to 0 and row increments. At row H-1, col W-1, both wrap to 0 and frame_done pulses on the next cycle.
- Window formation: window_valid is registered, set the cycle after accepting a pixel with row >= K_L-1 and col >= K_W-1. Latency is 1 cycle.
- Window clearing: window_valid clears on a window_valid && window_ready cycle with no qualifying accept. A handshake plus a qualifying accept in the same cycle keeps it at 1 with the new window.
- Windows per frame: (H-K_L+1)*(W-K_W+1).
- window_last: asserted with the window formed from pixel (H-1, W-1).
- Window stability: window and window_last stay constant while window_valid && !window_ready.
- Row boundaries: there is no bubble. Pixels with col < K_W-1 only fill the shift register and do not produce a window.
- Frames: back-to-back frames need no gap. Row-buffer data from the previous frame is never exposed, because windows require row >= K_L-1.
- Reset mid-frame: counters return to 0, window_valid drops immediately, and the next accepted pixel is treated as (0,0).
- pix_valid low: counters and window are held.

Optional Feature:
- Macro: CONV_WINDOW_POS_EN.
- When defined:
  - Adds outputs win_row (clog2(H) bits) and win_col (clog2(W) bits), the top-left coordinate of the current window.
  - They are registered together with window_valid and held under the same stability rule.
  - They reset to 0.
- When undefined: the ports are absent and the logic is not built.

Decomposition:
- Shared package conv_pkg:
  - localparams for window element count, flattened widths and counter widths (clog2 of H and W).
  - An index function elem_idx(a,r,c) giving the flattened bit offset, reused by the conv unit's bench.
- Sub-module line_buffer_row: one circular row buffer per channel and row, W x data_width, write/read at col, with a shift-out port. The block instantiates input_channel*(K_L-1) of them.

Test Plan:
- Defaults, channel 1; feed pix_in = 16'h0000+idx for idx 0..24 with pix_valid always high and window_ready always high.
  - First window_valid is 1 cycle after idx 12 is accepted.
  - Window = {0,1,2,5,6,7,10,11,12}.
  - 9 windows per frame, window_last on the window holding 24, frame_done pulse.
- input_channel=2; channel 1 carries 16'h0100+idx. The first window's channel-1 elements are {100,101,102,105,106,107,10A,10B,10C} at elem_idx(1,r,c).
- Hold window_ready low for 3 cycles on the first window.
  - pix_ready is low and window is stable all 3 cycles.
  - On release the next window, {1,2,3,6,7,8,11,12,13}, follows in the next cycle.
- Random pix_valid gaps (about 50%): the window sequence and count are identical to the gap-free run.
- Assert reset after idx 17.
  - window_valid drops immediately.
  - A restarted frame produces the window {0,1,2,5,6,7,10,11,12} first.
- Two frames back-to-back, second frame pixels 16'h1000+idx: the first window of frame 2 contains only 1xxx values; 18 windows total.
